// File: rtl/display_pkg.sv
// Shared definitions for the two-digit BCD seven-segment scanner.
//   - Active-high segment patterns in {g,f,e,d,c,b,a} order.
//   - Digit index encoding used by the scan state machine.
package display_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_TENS  = 1'b1
    } digit_e;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Load bus between the binary-to-BCD converter and the display scanner.
//   load  : single-cycle strobe, captures units/tens
//   units : BCD ones digit
//   tens  : BCD tens digit
// master = converter side (drives), slave = scanner side (receives).
interface bcd_display_scanner_if;
    logic       load;
    logic [3:0] units;
    logic [3:0] tens;

    modport master (output load, output units, output tens);
    modport slave  (input  load, input  units, input  tens);
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational BCD to seven-segment decoder.
//   digit : 4-bit code in
//   seg   : active-high segments {g,f,e,d,c,b,a}; codes 10..15 show a dash
module seven_seg_decode
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit time-multiplexed seven-segment display driver.
// New digit pairs are captured into a shadow register on load and only
// committed to the displayed value at a frame boundary, so a pair never
// tears mid-frame.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : slave side of the load bus (load, units, tens)
//   seg        : registered segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//   dig_en     : registered digit enables, [0]=units [1]=tens
//   pending    : shadow register holds an uncommitted value
//   frame_tick : one-cycle pulse when the scan wraps back to the units digit
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_display_scanner_if.slave bus,
    output logic [6:0]           seg,
    output logic [1:0]           dig_en,
    output logic                 pending,
    output logic                 frame_tick
);

    localparam int              DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam bit              BLANK_EN = (BLANK_LEADING != 0);
    localparam bit              INVERT   = (ACTIVE_LOW != 0);

    // Board polarity: everything inside is active-high until the output register.
    function automatic logic [6:0] seg_polarity(input logic [6:0] s);
        return INVERT ? ~s : s;
    endfunction

    function automatic logic [1:0] en_polarity(input logic [1:0] e);
        return INVERT ? ~e : e;
    endfunction

    logic [DIV_W-1:0] div_p0;
    digit_e           idx_p0;
    digit_e           idx_next;
    logic [3:0]       active_units_p0;
    logic [3:0]       active_tens_p0;
    logic [3:0]       shadow_units_p0;
    logic [3:0]       shadow_tens_p0;
    logic             pending_p0;
    logic             frame_tick_p0;
    logic [6:0]       seg_p1;
    logic [1:0]       dig_en_p1;

    logic             terminal;
    logic             boundary;
    logic [3:0]       digit_sel;
    logic [6:0]       seg_raw;
    logic             blank;

    assign terminal = (div_p0 == DIV_LAST);
    assign boundary = terminal && (idx_p0 == DIG_TENS);

    // ---- Stage p0: divider, digit index, shadow/active value ----
    always_comb begin
        idx_next = idx_p0;
        if (terminal) begin
            case (idx_p0)
                DIG_UNITS: idx_next = DIG_TENS;
                DIG_TENS:  idx_next = DIG_UNITS;
                default:   idx_next = DIG_UNITS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_p0 <= DIG_UNITS;
        end else begin
            idx_p0 <= idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_p0        <= '0;
            frame_tick_p0 <= 1'b0;
        end else begin
            div_p0        <= terminal ? '0 : div_p0 + 1'b1;
            frame_tick_p0 <= boundary;
        end
    end

    // A load landing on the boundary bypasses the shadow and commits directly,
    // otherwise the last load before the boundary wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_units_p0 <= 4'd0;
            shadow_tens_p0  <= 4'd0;
            active_units_p0 <= 4'd0;
            active_tens_p0  <= 4'd0;
            pending_p0      <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_units_p0 <= bus.units;
                shadow_tens_p0  <= bus.tens;
            end
            if (boundary) begin
                pending_p0 <= 1'b0;
                if (bus.load) begin
                    active_units_p0 <= bus.units;
                    active_tens_p0  <= bus.tens;
                end else if (pending_p0) begin
                    active_units_p0 <= shadow_units_p0;
                    active_tens_p0  <= shadow_tens_p0;
                end
            end else if (bus.load) begin
                pending_p0 <= 1'b1;
            end
        end
    end

    assign digit_sel = (idx_p0 == DIG_TENS) ? active_tens_p0 : active_units_p0;

    seven_seg_decode u_decode (
        .digit (digit_sel),
        .seg   (seg_raw)
    );

    // Blanking only clears segments; the tens enable still fires so the
    // scan duty cycle does not change.
    assign blank = BLANK_EN && (idx_p0 == DIG_TENS) && (active_tens_p0 == 4'd0);

    // ---- Stage p1: registered display outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p1    <= seg_polarity(SEG_OFF);
            dig_en_p1 <= en_polarity(2'b00);
        end else begin
            seg_p1    <= seg_polarity(blank ? SEG_OFF : seg_raw);
            dig_en_p1 <= en_polarity((idx_p0 == DIG_TENS) ? 2'b10 : 2'b01);
        end
    end

    assign seg        = seg_p1;
    assign dig_en     = dig_en_p1;
    assign pending    = pending_p0;
    assign frame_tick = frame_tick_p0;

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_display_scanner_if bus ();

    logic [6:0] seg_a, seg_b, seg_c;
    logic [1:0] den_a, den_b, den_c;
    logic       pend_a, pend_b, pend_c;
    logic       tick_a, tick_b, tick_c;

    int n_cmp = 0;
    int n_err = 0;

    // A: blanking on, active-high
    bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .seg(seg_a), .dig_en(den_a), .pending(pend_a), .frame_tick(tick_a));

    // B: blanking off, active-high
    bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(0), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .seg(seg_b), .dig_en(den_b), .pending(pend_b), .frame_tick(tick_b));

    // C: blanking off, active-low
    bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(0), .ACTIVE_LOW(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .seg(seg_c), .dig_en(den_c), .pending(pend_c), .frame_tick(tick_c));

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.load  = 1'b0;
        bus.units = 4'd0;
        bus.tens  = 4'd0;
        tick(2);

        // Reset state
        check("rst_seg_a",   {1'b0, seg_a}, 8'h00);
        check("rst_den_a",   {6'b0, den_a}, 8'h00);
        check("rst_pend_a",  {7'b0, pend_a}, 8'h00);
        check("rst_tick_a",  {7'b0, tick_a}, 8'h00);
        check("rst_seg_c",   {1'b0, seg_c}, 8'h7F);
        check("rst_den_c",   {6'b0, den_c}, 8'h03);
        check("rst_pend_c",  {7'b0, pend_c}, 8'h00);

        rst_n = 1'b1;
        tick(1);  // edge 1
        check("first_seg",   {1'b0, seg_a}, 8'h3F);
        check("first_den",   {6'b0, den_a}, 8'h01);
        tick(3);  // edge 4
        check("e4_den",      {6'b0, den_a}, 8'h01);
        check("e4_tick",     {7'b0, tick_a}, 8'h00);
        tick(1);  // edge 5
        check("e5_den",      {6'b0, den_a}, 8'h02);
        check("e5_blank",    {1'b0, seg_a}, 8'h00);
        check("e5_seg_b",    {1'b0, seg_b}, 8'h3F);
        tick(3);  // edge 8: frame boundary
        check("e8_tick",     {7'b0, tick_a}, 8'h01);
        check("e8_tick_c",   {7'b0, tick_c}, 8'h01);
        check("e8_den",      {6'b0, den_a}, 8'h02);
        tick(1);  // edge 9
        check("e9_tick",     {7'b0, tick_a}, 8'h00);
        check("e9_den",      {6'b0, den_a}, 8'h01);
        check("e9_seg",      {1'b0, seg_a}, 8'h3F);

        // Mid-frame load of 17
        bus.load = 1'b1; bus.units = 4'd7; bus.tens = 4'd1;
        tick(1);  // edge 10
        bus.load = 1'b0;
        check("ld17_pend",   {7'b0, pend_a}, 8'h01);
        check("ld17_pend_b", {7'b0, pend_b}, 8'h01);
        check("ld17_old",    {1'b0, seg_a}, 8'h3F);
        tick(5);  // edge 15
        check("ld17_pend15", {7'b0, pend_a}, 8'h01);
        check("ld17_blank",  {1'b0, seg_a}, 8'h00);
        tick(1);  // edge 16: commit
        check("ld17_commit", {7'b0, pend_a}, 8'h00);
        check("ld17_tick",   {7'b0, tick_a}, 8'h01);
        tick(1);  // edge 17
        check("ld17_units",  {1'b0, seg_a}, 8'h07);
        check("ld17_uden",   {6'b0, den_a}, 8'h01);
        tick(4);  // edge 21
        check("ld17_tens",   {1'b0, seg_a}, 8'h06);
        check("ld17_tden",   {6'b0, den_a}, 8'h02);

        // Two loads before the boundary: 23 then 45
        bus.load = 1'b1; bus.units = 4'd3; bus.tens = 4'd2;
        tick(1);  // edge 22
        bus.units = 4'd5; bus.tens = 4'd4;
        tick(1);  // edge 23
        bus.load = 1'b0;
        check("ld45_pend",   {7'b0, pend_a}, 8'h01);
        tick(1);  // edge 24: commit
        check("ld45_commit", {7'b0, pend_a}, 8'h00);
        tick(1);  // edge 25
        check("ld45_units",  {1'b0, seg_a}, 8'h6D);
        tick(4);  // edge 29
        check("ld45_tens",   {1'b0, seg_a}, 8'h66);

        // Load coincident with the boundary at edge 32
        tick(2);  // edge 31
        bus.load = 1'b1; bus.units = 4'd9; bus.tens = 4'd9;
        tick(1);  // edge 32
        bus.load = 1'b0;
        check("ld99_pend",   {7'b0, pend_a}, 8'h00);
        check("ld99_tick",   {7'b0, tick_a}, 8'h01);
        tick(1);  // edge 33
        check("ld99_units",  {1'b0, seg_a}, 8'h6F);
        check("ld99_pend33", {7'b0, pend_a}, 8'h00);
        tick(4);  // edge 37
        check("ld99_tens",   {1'b0, seg_a}, 8'h6F);

        // Non-BCD units with zero tens
        bus.load = 1'b1; bus.units = 4'd12; bus.tens = 4'd0;
        tick(1);  // edge 38
        bus.load = 1'b0;
        tick(3);  // edge 41
        check("dash_a",      {1'b0, seg_a}, 8'h40);
        check("dash_b",      {1'b0, seg_b}, 8'h40);
        check("dash_c",      {1'b0, seg_c}, 8'h3F);
        check("dash_den_c",  {6'b0, den_c}, 8'h02);
        tick(4);  // edge 45
        check("zero_a",      {1'b0, seg_a}, 8'h00);
        check("zero_b",      {1'b0, seg_b}, 8'h3F);
        check("zero_c",      {1'b0, seg_c}, 8'h40);
        check("zero_den_c",  {6'b0, den_c}, 8'h01);
        check("zero_den_b",  {6'b0, den_b}, 8'h02);

        // Reset during the tens slot with a value pending
        bus.load = 1'b1; bus.units = 4'd5; bus.tens = 4'd5;
        tick(1);  // edge 46
        bus.load = 1'b0;
        check("mrst_pend",   {7'b0, pend_a}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_seg_a",  {1'b0, seg_a}, 8'h00);
        check("mrst_den_a",  {6'b0, den_a}, 8'h00);
        check("mrst_pend_a", {7'b0, pend_a}, 8'h00);
        check("mrst_seg_c",  {1'b0, seg_c}, 8'h7F);
        check("mrst_den_c",  {6'b0, den_c}, 8'h03);
        tick(1);
        rst_n = 1'b1;
        tick(1);  // edge 1 after release
        check("rel_seg",     {1'b0, seg_a}, 8'h3F);
        check("rel_den",     {6'b0, den_a}, 8'h01);
        check("rel_pend",    {7'b0, pend_a}, 8'h00);
        tick(4);  // edge 5: tens digit 0 again
        check("rel_tens_a",  {1'b0, seg_a}, 8'h00);
        check("rel_tens_b",  {1'b0, seg_b}, 8'h3F);
        tick(4);  // edge 9: shadow 55 must not have been committed
        check("rel_units",   {1'b0, seg_a}, 8'h3F);
        check("rel_pend9",   {7'b0, pend_a}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream stage of the binary-to-BCD converter. Consumes its `units`/`tens` BCD digits and drives a two-digit, time-multiplexed seven-segment display.
- Captures new values on a load strobe into a shadow register.
- Commits the shadow register to the displayed value only at a frame boundary, so a digit pair never tears mid-frame.
- Scans the digits with a refresh divider, blanks a leading zero, and shows a dash for non-BCD codes.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays enabled; legal range ≥2.
- BLANK_LEADING, 1, when 1 a tens digit of 0 is blanked.
- ACTIVE_LOW, 1, when 1 the `seg` and `dig_en` outputs are inverted for an active-low board.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; captures `units`/`tens` into the shadow register.
- units  input  4  BCD ones digit from the converter.
- tens  input  4  BCD tens digit from the converter.
- seg  output  7  segments in {g,f,e,d,c,b,a} order, registered.
- dig_en  output  2  digit enables; [0]=units, [1]=tens; registered; one-hot or all-off.
- pending  output  1  high while the shadow register holds an uncommitted value.
- frame_tick  output  1  one-cycle pulse when the scan wraps from the tens digit back to the units digit.

Behaviour:
- Reset is asynchronous and active-low. While `rst_n`=0, all of the following hold:
  - divider=0, digit index=0.
  - active value=00, shadow value=00, pending=0, frame_tick=0.
  - `seg` all off and `dig_en` all off. With ACTIVE_LOW=1 that means 7'h7F and 2'b11.
- First cycle after reset release: registered outputs show units digit "0".
- Divider:
  - Counts 0..REFRESH_DIV-1.
  - At the terminal count it returns to 0 and toggles the digit index (0→1→0).
  - Slot length is exactly REFRESH_DIV cycles.
  - A full frame is 2*REFRESH_DIV cycles.
- Frame boundary is the terminal count while index=1. `frame_tick` is registered and asserts on the cycle index becomes 0.
- Load handshake:
  - `load`=1 writes `units`/`tens` into the shadow register and sets pending=1.
  - A repeated load before commit overwrites the shadow register; last one wins.
- Commit:
  - At a frame boundary with pending=1, active ← shadow and pending ← 0.
  - If `load` and a frame boundary coincide, the incoming `units`/`tens` go directly to active and pending ends at 0.
- Output stage:
  - Registered, one cycle after the index/active value.
  - `dig_en` selects the digit for the current index.
  - `seg` holds the decode of that digit, inverted if ACTIVE_LOW.
- Decode (active-high, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - 10..15 decode to dash = 40.
- Leading-zero blanking: BLANK_LEADING=1, index=1 and active tens=0 → `seg` all off. `dig_en[1]` still asserts, so scan timing is unchanged.
- Reset mid-frame: pending is discarded and the shadow value is lost; the block restarts from the reset state.

Decomposition:
- Shared package `display_pkg` holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - digit index constants DIG_UNITS=0, DIG_TENS=1.
- One combinational sub-module `seven_seg_decode`, 4-bit in, 7-bit active-high out, instantiated once on the muxed digit.
- Inversion and registering stay in the top module.

Test Plan (REFRESH_DIV=4, ACTIVE_LOW=0 unless stated):
- Reset then idle → `dig_en` alternates 01/10 every 4 cycles. `seg`=3F in the units slot and 00 in the tens slot (blanked). `frame_tick` pulses every 8 cycles.
- load with units=7, tens=1 mid-frame → pending=1 until the next boundary. Then units slot shows 07 and tens slot shows 06, pending=0.
- Two loads before a boundary (units/tens 23, then 45) → only 45 is displayed; 23 never appears.
- load coincident with the boundary (units/tens 9,9) → next units slot shows 6F, pending stays 0.
- units=12, tens=0 with BLANK_LEADING=0 → units slot shows 40, tens slot shows 3F. Repeat with ACTIVE_LOW=1 → the inverted values appear and `dig_en` is active-low.
- Assert `rst_n` low during the tens slot with pending=1 → outputs turn off asynchronously. After release the display shows units "0" with pending=0.
